// File: rtl/walk_stim_gen.sv
// Clocked walking-ones fill / walking-zeros drain stimulus source for a WIDTH-input gate block.
// Each pattern change is separated by DWELL cycles, and a TAIL period precedes the done pulse.
module walk_stim_gen #(
    parameter int WIDTH = 7,
    parameter int DWELL = 200,
    parameter int TAIL  = 700
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    output logic [WIDTH-1:0]                 pattern,
    output logic                             step_strobe,
    output logic [$clog2(2*WIDTH+1)-1:0]     step_idx,
    output logic                             busy,
    output logic                             done
);

    localparam int IDX_W   = $clog2(2*WIDTH+1);
    localparam int MAX_CNT = (DWELL > TAIL) ? DWELL : TAIL;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] FILL_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] DRAIN_LAST = IDX_W'(2*WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [WIDTH-1:0] PAT_ONE    = WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_TAIL} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Abort is checked ahead of every state so it also overrides a same-cycle terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pattern     <= '0;
            step_strobe <= 1'b0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state    <= S_IDLE;
                cnt      <= '0;
                pattern  <= '0;
                step_idx <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_FILL;
                            cnt      <= '0;
                            pattern  <= '0;
                            step_idx <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    S_FILL: begin
                        if (cnt == DWELL_LAST) begin
                            // p | (p+1) sets the lowest cleared bit
                            pattern     <= pattern | (pattern + PAT_ONE);
                            step_strobe <= 1'b1;
                            step_idx    <= step_idx + IDX_ONE;
                            cnt         <= '0;
                            if (step_idx == FILL_LAST) begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_DRAIN: begin
                        if (cnt == DWELL_LAST) begin
                            // p & (p-1) clears the lowest set bit
                            pattern     <= pattern & (pattern - PAT_ONE);
                            step_strobe <= 1'b1;
                            step_idx    <= step_idx + IDX_ONE;
                            cnt         <= '0;
                            if (step_idx == DRAIN_LAST) begin
                                state <= S_TAIL;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_TAIL: begin
                        if (cnt == TAIL_LAST) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
